// File: rtl/vec_mac_wide_pkg.sv
// Shared types for the modular-domain datapath: operand vectors and the wide
// signed accumulator vector passed from vec_mac_wide to the reducer.
package vec_mac_wide_pkg;

    localparam int N_SLOTS_L = 8;
    localparam int W_BITS_L  = 16;
    localparam int Q_MOD_L   = 32749;

    typedef logic [W_BITS_L-1:0]          word_t;
    typedef word_t [N_SLOTS_L-1:0]        vec_t;
    typedef logic signed [2*W_BITS_L-1:0] wide_t;
    typedef wide_t [N_SLOTS_L-1:0]        wide_vec_t;

endpackage

// File: rtl/vec_mac_wide_mac_lane_array.sv
// mac_lane_array: combinational LANES-wide multiply and add/subtract slice.
// Each lane forms an unsigned W x W product and folds it into a signed WW-bit acc.
module mac_lane_array
    import vec_mac_wide_pkg::*;
#(
    parameter int LANES = 4
) (
    input  word_t [LANES-1:0] a_i,
    input  word_t [LANES-1:0] b_i,
    input  wide_t [LANES-1:0] acc_i,
    input  logic              clear_i,
    input  logic              sub_i,
    output wide_t [LANES-1:0] acc_o
);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [2*W_BITS_L-1:0] prod;
        wide_t                 base;

        // Zero-extend before multiplying so the full 2W-bit product is kept.
        assign prod     = {{W_BITS_L{1'b0}}, a_i[k]} * {{W_BITS_L{1'b0}}, b_i[k]};
        assign base     = clear_i ? '0 : acc_i[k];
        assign acc_o[k] = sub_i ? (base - $signed(prod)) : (base + $signed(prod));
    end

endmodule

// File: rtl/vec_mac_wide.sv
// vec_mac_wide: sequential element-wise multiply-accumulate over up to MAX_TERMS
// operand pairs, LANES slots per cycle. Optional macro VEC_MAC_SUB_EN honours in_sub_i.
//
// state | meaning
// IDLE  | ready for an operand pair; partial sum may be open (term_cnt != 0)
// MUL   | multiplying LANES slots per cycle into the accumulator bank
// HOLD  | finished result presented on out_vec_o until out_ready_i
module vec_mac_wide
    import vec_mac_wide_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int MAX_TERMS = 2
) (
    input  logic      clk_i,
    input  logic      reset_i,
    input  logic      in_valid_i,
    output logic      in_ready_o,
    input  vec_t      a_vec_i,
    input  vec_t      b_vec_i,
    input  logic      in_last_i,
    input  logic      in_sub_i,
    output logic      out_valid_o,
    input  logic      out_ready_i,
    output wide_vec_t out_vec_o,
    output logic      busy_o,
    output logic      err_terms_o
);

    localparam int SLOTS = N_SLOTS_L / LANES;
    localparam int SC_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int TC_W  = $clog2(MAX_TERMS + 1);
    localparam int IDX_W = (N_SLOTS_L > 1) ? $clog2(N_SLOTS_L) : 1;

    if (N_SLOTS_L % LANES != 0) begin : g_bad_lanes
        $error("vec_mac_wide: N_SLOTS_L must be a multiple of LANES");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    vec_t             a_q, a_d;
    vec_t             b_q, b_d;
    logic             last_q, last_d;
    logic             sub_q, sub_d;
    logic [SC_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [TC_W-1:0]  term_cnt_q, term_cnt_d;
    wide_vec_t        acc_q, acc_d;
    logic             err_q, err_d;

    logic             sub_eff;
    logic             force_last;
    logic             slot_wrap;
    logic [IDX_W-1:0] slot_base;

    word_t [LANES-1:0] a_sl;
    word_t [LANES-1:0] b_sl;
    wide_t [LANES-1:0] acc_sl;
    wide_t [LANES-1:0] acc_nx;

`ifdef VEC_MAC_SUB_EN
    assign sub_eff = in_sub_i;
`else
    logic unused_in_sub;
    assign unused_in_sub = in_sub_i;
    assign sub_eff       = 1'b0;
`endif

    // A term arriving when only one slot is left closes the result regardless of in_last.
    assign force_last = (term_cnt_q == TC_W'(MAX_TERMS - 1)) && !in_last_i;
    assign slot_wrap  = (slot_cnt_q == SC_W'(SLOTS - 1));
    assign slot_base  = IDX_W'(int'(slot_cnt_q) * LANES);

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            a_sl[k]   = a_q[slot_base + IDX_W'(k)];
            b_sl[k]   = b_q[slot_base + IDX_W'(k)];
            acc_sl[k] = acc_q[slot_base + IDX_W'(k)];
        end
    end

    mac_lane_array #(
        .LANES (LANES)
    ) u_lanes (
        .a_i     (a_sl),
        .b_i     (b_sl),
        .acc_i   (acc_sl),
        .clear_i (term_cnt_q == '0),
        .sub_i   (sub_q),
        .acc_o   (acc_nx)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            last_q     <= 1'b0;
            sub_q      <= 1'b0;
            slot_cnt_q <= '0;
            term_cnt_q <= '0;
            acc_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            last_q     <= last_d;
            sub_q      <= sub_d;
            slot_cnt_q <= slot_cnt_d;
            term_cnt_q <= term_cnt_d;
            acc_q      <= acc_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        last_d     = last_q;
        sub_d      = sub_q;
        slot_cnt_d = slot_cnt_q;
        term_cnt_d = term_cnt_q;
        acc_d      = acc_q;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    a_d        = a_vec_i;
                    b_d        = b_vec_i;
                    last_d     = in_last_i | force_last;
                    sub_d      = sub_eff;
                    slot_cnt_d = '0;
                    err_d      = force_last;
                    state_d    = ST_MUL;
                end
            end
            ST_MUL: begin
                for (int k = 0; k < LANES; k++) begin
                    acc_d[slot_base + IDX_W'(k)] = acc_nx[k];
                end
                if (slot_wrap) begin
                    slot_cnt_d = '0;
                    term_cnt_d = term_cnt_q + TC_W'(1);
                    state_d    = last_q ? ST_HOLD : ST_IDLE;
                end else begin
                    slot_cnt_d = slot_cnt_q + SC_W'(1);
                end
            end
            ST_HOLD: begin
                if (out_ready_i) begin
                    term_cnt_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == ST_IDLE);
        out_valid_o = (state_q == ST_HOLD);
        busy_o      = (state_q != ST_IDLE) || (term_cnt_q != '0);
        err_terms_o = err_q;
    end

    assign out_vec_o = acc_q;

endmodule

// File: tb/tb_vec_mac_wide.sv
// Bench for vec_mac_wide (N=8, LANES=2, W=16, MAX_TERMS=2): directed pairs against a
// queue-based result model plus hand-computed lane values.
module tb_vec_mac_wide;
    import vec_mac_wide_pkg::*;

    localparam int LANES = 2;
    localparam int MAXT  = 2;
    localparam int SLOTS = N_SLOTS_L / LANES;

    logic      clk = 1'b0;
    logic      reset = 1'b1;
    logic      in_valid = 1'b0;
    logic      in_last = 1'b0;
    logic      in_sub = 1'b0;
    logic      out_ready = 1'b1;
    vec_t      a_vec = '0;
    vec_t      b_vec = '0;
    logic      in_ready, out_valid, busy, err_terms;
    wide_vec_t out_vec;

    always #5 clk = ~clk;

    vec_mac_wide #(
        .LANES     (LANES),
        .MAX_TERMS (MAXT)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_vec_i     (a_vec),
        .b_vec_i     (b_vec),
        .in_last_i   (in_last),
        .in_sub_i    (in_sub),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_vec_o   (out_vec),
        .busy_o      (busy),
        .err_terms_o (err_terms)
    );

    int checks = 0;
    int errors = 0;
    int err_seen = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Result model: a pair occupies the multiplier for SLOTS cycles; a result that
    // closes (last or term limit) is then held until out_ready.
    longint    m_acc [N_SLOTS_L];
    wide_vec_t exp_q [$];
    wide_vec_t m_vec;
    int        m_cnt = 0;
    int        m_terms = 0;
    bit        m_hold = 0;
    bit        m_pend = 0;
    bit        m_err = 0;
    bit        m_live = 0;
    bit        m_rdy, m_fin, m_sub;
    longint    m_prod;
    int        edge_no = 0;
    int        accept_edge = 0;

    always @(posedge clk) begin
        edge_no++;
        m_live = 1;
        if (reset) begin
            for (int i = 0; i < N_SLOTS_L; i++) m_acc[i] = 0;
            exp_q.delete();
            m_cnt = 0; m_terms = 0; m_hold = 0; m_pend = 0; m_err = 0;
        end else begin
            m_rdy = (m_cnt == 0) && !m_hold;
            m_err = 0;
            if (m_hold && out_ready) begin
                m_hold  = 0;
                m_terms = 0;
                void'(exp_q.pop_front());
            end
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0 && m_pend) begin
                    m_hold = 1;
                    m_pend = 0;
                end
            end else if (m_rdy && in_valid) begin
`ifdef VEC_MAC_SUB_EN
                m_sub = in_sub;
`else
                m_sub = 0;
`endif
                m_fin = in_last || (m_terms == MAXT - 1);
                m_err = !in_last && (m_terms == MAXT - 1);
                for (int i = 0; i < N_SLOTS_L; i++) begin
                    m_prod = longint'(a_vec[i]) * longint'(b_vec[i]);
                    m_acc[i] = m_sub ? m_acc[i] - m_prod : m_acc[i] + m_prod;
                end
                m_terms++;
                m_cnt = SLOTS;
                accept_edge = edge_no;
                if (m_fin) begin
                    for (int i = 0; i < N_SLOTS_L; i++) begin
                        m_vec[i] = wide_t'(m_acc[i]);
                        m_acc[i] = 0;
                    end
                    exp_q.push_back(m_vec);
                    m_pend = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready", in_ready, (m_cnt == 0) && !m_hold);
            check("out_valid", out_valid, m_hold);
            check("busy", busy, (m_cnt > 0) || m_hold || (m_terms != 0));
            check("err_terms", err_terms, m_err);
            if (err_terms === 1'b1) err_seen++;
            if (m_hold) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL model_queue actual=empty expected=pending result");
                end else begin
                    for (int i = 0; i < N_SLOTS_L; i++) begin
                        check($sformatf("out_vec[%0d]", i), $signed(out_vec[i]), $signed(exp_q[0][i]));
                        check("acc_range", (out_vec[i] == 32'sh8000_0000) ? 1 : 0, 0);
                    end
                end
            end
        end
    end

    task automatic send(input int av, input int bv, input bit last, input bit sub);
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=in_ready low expected=in_ready high");
        end
        for (int i = 0; i < N_SLOTS_L; i++) begin
            a_vec[i] = word_t'(av);
            b_vec[i] = word_t'(bv);
        end
        in_valid = 1'b1;
        in_last  = last;
        in_sub   = sub;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_sub   = 1'b0;
    endtask

    task automatic expect_result(input string name, input longint lane, input int latency);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=no out_valid expected=out_valid", name);
        end else begin
            for (int i = 0; i < N_SLOTS_L; i++) check(name, $signed(out_vec[i]), lane);
            if (latency > 0) check({name, "_latency"}, edge_no - accept_edge, latency);
            if (out_ready) @(negedge clk);
        end
    endtask

    initial begin
        int e0;
        longint t3_exp;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_terms, 0);
        for (int i = 0; i < N_SLOTS_L; i++) check("rst_out_vec", $signed(out_vec[i]), 0);

        // single term 3*5
        send(3, 5, 1, 0);
        expect_result("t1_lane", 15, 4);
        check("t1_ready_after", in_ready, 1);
        check("t1_busy_after", busy, 0);

        // two terms at the largest residue
        e0 = err_seen;
        send(32748, 32748, 0, 0);
        send(32748, 32748, 1, 0);
        expect_result("t2_lane", 64'sd2144863008, 0);
        check("t2_no_err", err_seen - e0, 0);

`ifdef VEC_MAC_SUB_EN
        t3_exp = -14;
`else
        t3_exp = 26;
`endif
        send(2, 3, 0, 0);
        send(4, 5, 1, 1);
        expect_result("t3_lane", t3_exp, 0);

        // backpressure with ignored in_valid pulses
        out_ready = 1'b0;
        send(1, 2, 1, 0);
        expect_result("t4_lane", 2, 4);
        for (int c = 0; c < 10; c++) begin
            in_valid = (c % 2 == 0);
            for (int i = 0; i < N_SLOTS_L; i++) begin
                a_vec[i] = word_t'(9);
                b_vec[i] = word_t'(9);
            end
            @(negedge clk);
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_lane0", $signed(out_vec[0]), 2);
            check("t4_hold_lane7", $signed(out_vec[7]), 2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_released", out_valid, 0);
        send(1, 1, 1, 0);
        expect_result("t4_next", 1, 0);

        // term limit reached without last
        e0 = err_seen;
        send(2, 2, 0, 0);
        send(3, 3, 0, 0);
        expect_result("t5_lane", 13, 0);
        check("t5_err_pulses", err_seen - e0, 1);

        // reset during the third multiply cycle
        send(5, 5, 1, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_out_valid", out_valid, 0);
        check("t6_in_ready", in_ready, 1);
        check("t6_busy", busy, 0);
        check("t6_acc0", $signed(out_vec[0]), 0);
        check("t6_acc5", $signed(out_vec[5]), 0);
        repeat (6) begin
            @(negedge clk);
            check("t6_no_emit", out_valid, 0);
        end
        send(1, 7, 1, 0);
        expect_result("t6_lane", 7, 4);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
